// File: rtl/pc_unit.sv
// pc_unit: registered program counter with stall, conditional branch,
// pseudo-direct jump, register jump and call/return through a circular
// return-address stack.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   stall          hold PC, RAS and misalign_err for this cycle
//   branch_taken   take branch to pc_plus4 + (branch_offset << 2)
//   branch_offset  sign-extended word offset
//   jump           pseudo-direct jump {pc_plus4[top], jump_index, 2'b00}
//   jump_index     26-bit jump word index
//   jr             jump to jr_target (low two bits cleared)
//   jr_target      register jump target, also the fallback for ret on empty RAS
//   call           push pc_plus4 when the selected source is jump or jr
//   ret            pop RAS and jump to the popped address
//   PC             current program counter
//   pc_plus4       PC + 4 (combinational)
//   ras_empty      RAS holds no entries
//   ras_full       RAS holds RAS_DEPTH entries
//   misalign_err   one-cycle flag: last jr/ret target had nonzero bits [1:0]
module pc_unit #(
   parameter int unsigned           INST_WIDTH = 32,
   parameter logic [INST_WIDTH-1:0] RESET_ADDR = '0,
   parameter int unsigned           RAS_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic [INST_WIDTH-1:0] branch_offset,
   input  logic                  jump,
   input  logic [25:0]           jump_index,
   input  logic                  jr,
   input  logic [INST_WIDTH-1:0] jr_target,
   input  logic                  call,
   input  logic                  ret,
   output logic [INST_WIDTH-1:0] PC,
   output logic [INST_WIDTH-1:0] pc_plus4,
   output logic                  ras_empty,
   output logic                  ras_full,
   output logic                  misalign_err
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(RAS_DEPTH);
   // Bits below 28 come from the jump index; bits above come from pc_plus4.
   localparam logic [INST_WIDTH-1:0] LOW28_MASK = INST_WIDTH'(28'hFFF_FFFF);

   typedef enum logic [2:0] {
      SRC_SEQ,
      SRC_BRANCH,
      SRC_JUMP,
      SRC_JR,
      SRC_RET
   } src_t;

   logic [INST_WIDTH-1:0] pc_q;
   logic [INST_WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]      top_ptr;
   logic [CNT_W-1:0]      count;
   logic                  misalign_q;

   src_t                  src;
   logic [INST_WIDTH-1:0] ras_top;
   logic [INST_WIDTH-1:0] raw_target;
   logic [INST_WIDTH-1:0] jump_target;
   logic [INST_WIDTH-1:0] branch_target;
   logic [INST_WIDTH-1:0] next_pc;
   logic                  ras_nonempty;
   logic                  indirect;
   logic                  do_push;
   logic                  do_pop;
   logic                  do_replace;
   logic                  ras_we;
   logic [PTR_W-1:0]      ras_waddr;

   assign PC           = pc_q;
   assign pc_plus4     = pc_q + INST_WIDTH'(4);
   assign ras_empty    = (count == '0);
   assign ras_full     = (count == CNT_FULL);
   assign misalign_err = misalign_q;
   assign ras_nonempty = (count != '0);
   assign ras_top      = ras_mem[top_ptr];

   // Next-PC source selection and target computation
   always_comb begin
      src = SRC_SEQ;
      if (ret)
         src = SRC_RET;
      else if (jr)
         src = SRC_JR;
      else if (jump)
         src = SRC_JUMP;
      else if (branch_taken)
         src = SRC_BRANCH;

      jump_target   = (pc_plus4 & ~LOW28_MASK) | INST_WIDTH'({jump_index, 2'b00});
      branch_target = pc_plus4 + (branch_offset << 2);

      // ret on an empty stack falls back to the register target
      raw_target = jr_target;
      if ((src == SRC_RET) && ras_nonempty)
         raw_target = ras_top;

      indirect = (src == SRC_RET) || (src == SRC_JR);

      case (src)
         SRC_RET,
         SRC_JR:     next_pc = {raw_target[INST_WIDTH-1:2], 2'b00};
         SRC_JUMP:   next_pc = jump_target;
         SRC_BRANCH: next_pc = branch_target;
         default:    next_pc = pc_plus4;
      endcase
   end

   // RAS update decisions
   always_comb begin
      do_push    = call && ((src == SRC_JUMP) || (src == SRC_JR));
      do_pop     = (src == SRC_RET) && !call && ras_nonempty;
      // call+ret rewrites the top slot in place; when empty that slot is
      // stale, so writing it there and setting count to 1 is equivalent
      // to a push
      do_replace = (src == SRC_RET) && call;
      ras_we     = !reset && !stall && (do_push || do_replace);
      ras_waddr  = do_replace ? top_ptr : top_ptr + PTR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_ADDR;
         top_ptr    <= '0;
         count      <= '0;
         misalign_q <= 1'b0;
      end else if (!stall) begin
         pc_q       <= next_pc;
         misalign_q <= indirect && (raw_target[1:0] != 2'b00);
         if (do_push) begin
            top_ptr <= top_ptr + PTR_W'(1);
            if (count != CNT_FULL)
               count <= count + CNT_W'(1);
         end else if (do_pop) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - CNT_W'(1);
         end else if (do_replace && !ras_nonempty) begin
            count <= CNT_W'(1);
         end
      end
   end

   // Stack storage carries no reset: count alone decides what is readable
   always_ff @(posedge clk) begin
      if (ras_we)
         ras_mem[ras_waddr] <= pc_plus4;
   end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

   localparam int unsigned W     = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RST_A = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic        jump;
   logic [25:0] jump_index;
   logic        jr;
   logic [31:0] jr_target;
   logic        call;
   logic        ret;
   logic [31:0] PC;
   logic [31:0] pc_plus4;
   logic        ras_empty;
   logic        ras_full;
   logic        misalign_err;

   pc_unit #(
      .INST_WIDTH (W),
      .RESET_ADDR (RST_A),
      .RAS_DEPTH  (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_index    (jump_index),
      .jr            (jr),
      .jr_target     (jr_target),
      .call          (call),
      .ret           (ret),
      .PC            (PC),
      .pc_plus4      (pc_plus4),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .misalign_err  (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        empty;
      logic        full;
      logic        mis;
      bit          has_const;
      logic [31:0] const_pc;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;

   // reference model state: stack as a queue, newest entry at the back
   logic [31:0] m_pc;
   logic        m_mis;
   logic [31:0] m_ras[$];

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   // monitor: one expected entry per stimulated edge
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         cmp({e.name, ".pc"},       PC,                  e.pc);
         cmp({e.name, ".pc_plus4"}, pc_plus4,            e.pc4);
         cmp({e.name, ".empty"},    {31'd0, ras_empty},  {31'd0, e.empty});
         cmp({e.name, ".full"},     {31'd0, ras_full},   {31'd0, e.full});
         cmp({e.name, ".misalign"}, {31'd0, misalign_err}, {31'd0, e.mis});
         if (e.has_const)
            cmp({e.name, ".plan"}, PC, e.const_pc);
      end
   end

   task automatic step(input logic rst, input logic st, input logic bt,
                       input logic [31:0] boff, input logic jp, input logic [25:0] ji,
                       input logic j_r, input logic [31:0] jt, input logic cl,
                       input logic rt, input bit chk, input logic [31:0] cpc,
                       input string nm);
      logic [31:0] p4, tgt, npc;
      bit          ind;
      exp_t        e;
      @(negedge clk);
      reset = rst; stall = st; branch_taken = bt; branch_offset = boff;
      jump = jp; jump_index = ji; jr = j_r; jr_target = jt; call = cl; ret = rt;

      p4 = m_pc + 32'd4;
      if (rst) begin
         m_pc  = RST_A;
         m_mis = 1'b0;
         m_ras.delete();
      end else if (!st) begin
         ind = 1'b0;
         tgt = jt;
         if (rt) begin
            ind = 1'b1;
            if (m_ras.size() > 0) tgt = m_ras[$];
            if (cl) begin
               if (m_ras.size() > 0) m_ras[$] = p4;
               else m_ras.push_back(p4);
            end else if (m_ras.size() > 0) begin
               void'(m_ras.pop_back());
            end
            npc = tgt & ~32'd3;
         end else if (j_r) begin
            ind = 1'b1;
            npc = jt & ~32'd3;
         end else if (jp) begin
            npc = {p4[31:28], ji, 2'b00};
         end else if (bt) begin
            npc = p4 + (boff * 32'd4);
         end else begin
            npc = p4;
         end
         if (cl && !rt && (j_r || jp)) begin
            m_ras.push_back(p4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         end
         m_mis = ind && (tgt[1:0] != 2'b00);
         m_pc  = npc;
      end

      e.pc        = m_pc;
      e.pc4       = m_pc + 32'd4;
      e.empty     = (m_ras.size() == 0);
      e.full      = (m_ras.size() == DEPTH);
      e.mis       = m_mis;
      e.has_const = chk;
      e.const_pc  = cpc;
      e.name      = nm;
      sb.push_back(e);
   endtask

   // shorthands for common stimulus shapes
   task automatic seq(input string nm, input bit chk, input logic [31:0] cpc);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, chk, cpc, nm);
   endtask

   task automatic go_jr(input logic [31:0] t, input string nm);
      step(0, 0, 0, 0, 0, 0, 1, t, 0, 0, 1, t & ~32'd3, nm);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
      jump = 1'b0; jump_index = '0; jr = 1'b0; jr_target = '0; call = 1'b0; ret = 1'b0;
      m_pc = '0; m_mis = 1'b0;

      // reset and free-running count
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, "reset");
      seq("seq1", 1, 32'h4);
      seq("seq2", 1, 32'h8);
      seq("seq3", 1, 32'hC);
      seq("seq4", 1, 32'h10);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, "reset_mid");

      // branch and stall
      go_jr(32'h100, "to_100");
      step(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0, 1, 32'hFC, "branch_m2");
      for (int i = 0; i < 3; i++)
         step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFC, "stall");
      step(0, 1, 0, 0, 1, 26'h3FF, 0, 0, 1, 1, 1, 32'hFC, "stall_jump");

      // pseudo-direct jump then misaligned jr
      go_jr(32'h4000_0010, "to_4000");
      step(0, 0, 0, 0, 1, 26'h123, 0, 0, 0, 0, 1, 32'h4000_048C, "jump");
      step(0, 0, 0, 0, 0, 0, 1, 32'h2002, 0, 0, 1, 32'h2000, "jr_mis");
      seq("after_mis", 1, 32'h2004);

      // RAS fill, overflow, drain, empty fallback
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, "reset_ras");
      step(0, 0, 0, 0, 1, 26'h40,  0, 0, 1, 0, 1, 32'h100, "call1");
      step(0, 0, 0, 0, 1, 26'h80,  0, 0, 1, 0, 1, 32'h200, "call2");
      step(0, 0, 0, 0, 1, 26'hC0,  0, 0, 1, 0, 1, 32'h300, "call3");
      step(0, 0, 0, 0, 1, 26'h100, 0, 0, 1, 0, 1, 32'h400, "call4");
      step(0, 0, 0, 0, 1, 26'h200, 0, 0, 1, 0, 1, 32'h800, "call5");
      step(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 1, 32'h404, "ret1");
      step(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 1, 32'h304, "ret2");
      step(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 1, 32'h204, "ret3");
      step(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 1, 32'h104, "ret4");
      step(0, 0, 0, 0, 0, 0, 0, 32'h600, 0, 1, 1, 32'h600, "ret5_fallback");

      // call+ret on an empty stack
      go_jr(32'h80, "to_80");
      step(0, 0, 0, 0, 0, 0, 1, 32'h500, 1, 1, 1, 32'h500, "call_ret_empty");
      step(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 1, 32'h84, "ret_after");

      // wrap-around
      go_jr(32'hFFFF_FFFC, "to_top");
      seq("wrap", 1, 32'h0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic        r_rst, r_st, r_bt, r_jp, r_jr, r_cl, r_rt;
         logic [31:0] r_off;
         r_rst = ($urandom_range(0, 99) < 2);
         r_st  = ($urandom_range(0, 9) == 0);
         r_rt  = ($urandom_range(0, 5) == 0);
         r_jr  = ($urandom_range(0, 5) == 0);
         r_jp  = ($urandom_range(0, 4) == 0);
         r_bt  = ($urandom_range(0, 3) == 0);
         r_cl  = ($urandom_range(0, 2) == 0);
         r_off = 32'($urandom_range(0, 63)) - 32'd32;
         step(r_rst, r_st, r_bt, r_off, r_jp, 26'($urandom), r_jr, $urandom,
              r_cl, r_rt, 0, 0, "rand");
      end

      @(negedge clk);
      reset = 1'b0; stall = 1'b1; jump = 1'b0; jr = 1'b0; ret = 1'b0; call = 1'b0;
      for (int i = 0; i < 10 && sb.size() > 0; i++)
         @(negedge clk);
      if (sb.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
